// File: rtl/rtc_display_snapshot.sv
// Vblank-triggered snapshot of packed-BCD RTC fields into ASCII display registers,
// with cursor blink, alarm bar and a registered colour stage. Optional macro: ALARM_FLASH_EN.
module rtc_display_snapshot #(
    parameter int          NUM_FIELDS   = 11,
    parameter int          V_ACTIVE     = 480,
    parameter int          ALARM_BAR_H  = 8,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] ALARM_COLOR  = 12'hF00,
    parameter logic [11:0] BG_COLOR     = 12'h0F7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               pixely,
    input  logic                     video_on,
    input  logic [8*NUM_FIELDS-1:0]  datos_in,
    input  logic                     freeze,
    input  logic [7:0]               cursor,
    input  logic                     Escribir,
    input  logic                     ring,
    input  logic                     graficos,
    input  logic [11:0]              dato_memoria,
    input  logic [2:0]               color_addr,
    input  logic                     dp,
    output logic [14*NUM_FIELDS-1:0] ascii_out,
    output logic                     snap_done,
    output logic                     capture_err,
    output logic                     blink_phase,
    output logic [11:0]              rgbO
);

    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_FIELDS - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]       V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]       BAR_TOP    = 10'(V_ACTIVE - ALARM_BAR_H);
    localparam logic [9:0]       BAR_BOT    = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    function automatic logic [6:0] nibble_to_ascii(input logic [3:0] n);
        logic [6:0] a;
        if (n <= 4'd9) begin
            a = 7'h30 + {3'b000, n};
        end else begin
            a = 7'h2D;
        end
        return a;
    endfunction

    function automatic logic [13:0] bcd_to_ascii(input logic [7:0] b);
        return {nibble_to_ascii(b[7:4]), nibble_to_ascii(b[3:0])};
    endfunction

    function automatic logic [11:0] palette(input logic [2:0] i);
        logic [11:0] c;
        case (i)
            3'd0:    c = 12'h032;
            3'd1:    c = 12'h000;
            3'd2:    c = 12'hFFE;
            3'd3:    c = 12'h111;
            3'd4:    c = 12'h222;
            3'd5:    c = 12'h333;
            3'd6:    c = 12'h032;
            3'd7:    c = 12'h120;
            default: c = 12'h032;
        endcase
        return c;
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  idx_r;
    logic              vblank_s;
    logic              vblank_r;
    logic              vblank_rise_s;
    logic              cap_en_s;
    logic              commit_s;
    logic              abort_s;
    logic [7:0]        field_byte_s;
    logic [13:0]       field_ascii_s;
    logic [13:0]       shadow_r [NUM_FIELDS];
    logic [13:0]       disp_r   [NUM_FIELDS];
    logic              snap_done_r;
    logic              capture_err_r;
    logic [CNT_W-1:0]  blink_cnt_r;
    logic              blink_phase_r;
    logic              blank_en_s;
    logic              alarm_on_s;
    logic              in_bar_s;
    logic [11:0]       rgb_s;
    logic [11:0]       rgb_r;

    assign vblank_s      = (pixely >= V_ACT);
    assign vblank_rise_s = vblank_s & ~vblank_r;

    // Previous-cycle vblank level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_r <= 1'b0;
        end else begin
            vblank_r <= vblank_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state and capture/commit/abort strobes
    always_comb begin
        state_s  = state_r;
        cap_en_s = 1'b0;
        commit_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vblank_rise_s && !freeze) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (!vblank_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (idx_r == LAST_IDX) begin
                    cap_en_s = 1'b1;
                    commit_s = 1'b1;
                    state_s  = ST_COMMIT;
                end else begin
                    cap_en_s = 1'b1;
                    state_s  = ST_CAPTURE;
                end
            end
            ST_COMMIT: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One-hot field select of the byte currently being captured
    always_comb begin
        field_byte_s = 8'h00;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            field_byte_s = field_byte_s | ({8{idx_r == IDX_W'(k)}} & datos_in[8*k +: 8]);
        end
        field_ascii_s = bcd_to_ascii(field_byte_s);
    end

    // Shadow capture and display commit; the last field bypasses the shadow so the
    // whole bank lands in the display registers on the same edge as snap_done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r         <= '0;
            snap_done_r   <= 1'b0;
            capture_err_r <= 1'b0;
            for (int k = 0; k < NUM_FIELDS; k++) begin
                shadow_r[k] <= {7'h30, 7'h30};
                disp_r[k]   <= {7'h30, 7'h30};
            end
        end else begin
            snap_done_r   <= commit_s;
            capture_err_r <= abort_s;
            if (state_r != ST_CAPTURE) begin
                idx_r <= '0;
            end else if (cap_en_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= idx_r;
            end
            if (cap_en_s) begin
                shadow_r[idx_r] <= field_ascii_s;
            end
            if (commit_s) begin
                for (int k = 0; k < NUM_FIELDS; k++) begin
                    disp_r[k] <= (idx_r == IDX_W'(k)) ? field_ascii_s : shadow_r[k];
                end
            end
        end
    end

    // Frame-based blink counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (vblank_rise_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r   <= blink_cnt_r + CNT_W'(1);
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            blink_cnt_r   <= blink_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

    // Cursor-field blanking applied on the display registers
    always_comb begin
        ascii_out  = '0;
        blank_en_s = Escribir && !blink_phase_r && ({24'd0, cursor} < 32'(NUM_FIELDS));
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (blank_en_s && ({24'd0, cursor} == 32'(k))) begin
                ascii_out[14*k +: 14] = {7'h20, 7'h20};
            end else begin
                ascii_out[14*k +: 14] = disp_r[k];
            end
        end
    end

    // Pixel colour priority selection
    always_comb begin
`ifdef ALARM_FLASH_EN
        alarm_on_s = blink_phase_r;
`else
        alarm_on_s = 1'b1;
`endif
        in_bar_s = (pixely >= BAR_TOP) && (pixely <= BAR_BOT);
        if (!(video_on && dp)) begin
            rgb_s = BG_COLOR;
        end else if (graficos) begin
            rgb_s = dato_memoria;
        end else if (ring && alarm_on_s && in_bar_s) begin
            rgb_s = ALARM_COLOR;
        end else begin
            rgb_s = palette(color_addr);
        end
    end

    // Registered colour output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= rgb_s;
        end
    end

    assign snap_done   = snap_done_r;
    assign capture_err = capture_err_r;
    assign blink_phase = blink_phase_r;
    assign rgbO        = rgb_r;

endmodule
